approx_add_recover: RTL and testbench

APPROX_ADD_RECOVER -- requirements
Module: approx_add_recover

---
 rtl/approx_add_pkg.sv | 17 +
 rtl/cla4_pg_slice.sv | 42 ++++
 rtl/approx_add_recover.sv | 171 +++++++++++++++++
 tb/tb_approx_add_recover.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_pkg.sv
// ---------------------------------------------------------------------------
// approx_add_pkg
// Shared definitions for the approximate / carry-recovering adder.
//   SLICE_W : width of one carry-lookahead slice (4 bits)
//   state_t : controller states (IDLE, CHECK, HOLD)
// ---------------------------------------------------------------------------
package approx_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : approx_add_pkg

// File: rtl/cla4_pg_slice.sv
// ---------------------------------------------------------------------------
// cla4_pg_slice
// One 4-bit carry-lookahead slice.
// Ports:
//   a, b   : 4-bit operand slices
//   c_in   : carry into the slice
//   sum    : low 4 bits of a + b + c_in
//   p_grp  : group propagate (all four bit-propagates set)
//   g_grp  : group generate, independent of c_in, so it equals the
//            carry-out the slice would produce with a zero carry-in
// ---------------------------------------------------------------------------
module cla4_pg_slice
  import approx_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               p_grp,
  output logic               g_grp
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;   // carry into each bit position

  assign p = a ^ b;
  assign g = a & b;

  // Lookahead carries inside the slice
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  assign sum   = p ^ c;
  assign p_grp = &p;
  assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla4_pg_slice

// File: rtl/approx_add_recover.sv
// ---------------------------------------------------------------------------
// approx_add_recover
// Slice-parallel adder that first guesses every inter-slice carry from the
// slice generate terms alone, then (in exact mode) refines the carry vector
// one ripple step per clock until it stops changing.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin, exact    : operands, carry-in, mode (1 = iterate to exact)
//   out_valid/out_ready : result handshake
//   sum, cout           : result
//   err_flag            : result differed, or would have, from exact addition
//   fix_cnt             : correction iterations used
// ---------------------------------------------------------------------------
module approx_add_recover
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        cin,
  input  logic                        exact,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            sum,
  output logic                        cout,
  output logic                        err_flag,
  output logic [$clog2(WIDTH/4):0]    fix_cnt
);

  localparam int S  = WIDTH / SLICE_W;
  localparam int FW = $clog2(S) + 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             exact_reg, exact_next;
  logic [S-1:0]     creg_reg, creg_next;
  logic [FW-1:0]    fix_cnt_reg, fix_cnt_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             err_reg, err_next;

  // Slice datapath
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] slice_sum;
  logic [S-1:0]     p_vec;
  logic [S-1:0]     g_vec;
  logic [S-1:0]     nxt_carry;

  // While idle the slices look at the live inputs so the initial carry guess
  // (the group generates) is available on the accepting edge. Afterwards they
  // work on the captured operands.
  assign op_a = (state_reg == IDLE) ? a : a_reg;
  assign op_b = (state_reg == IDLE) ? b : b_reg;

  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_slice
      cla4_pg_slice u_slice (
        .a     (op_a[gi*SLICE_W +: SLICE_W]),
        .b     (op_b[gi*SLICE_W +: SLICE_W]),
        .c_in  (creg_reg[gi]),
        .sum   (slice_sum[gi*SLICE_W +: SLICE_W]),
        .p_grp (p_vec[gi]),
        .g_grp (g_vec[gi])
      );
    end
  endgenerate

  // One ripple step of carry refinement: each slice carry-in becomes the
  // carry-out of the slice below given that slice's current carry-in.
  // creg_reg[0] already holds the captured cin.
  assign nxt_carry[0] = creg_reg[0];
  generate
    for (genvar gi = 0; gi < S - 1; gi++) begin : g_nxt
      assign nxt_carry[gi+1] = g_vec[gi] | (p_vec[gi] & creg_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      exact_reg   <= 1'b0;
      creg_reg    <= '0;
      fix_cnt_reg <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      exact_reg   <= exact_next;
      creg_reg    <= creg_next;
      fix_cnt_reg <= fix_cnt_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    exact_next   = exact_reg;
    creg_next    = creg_reg;
    fix_cnt_next = fix_cnt_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next       = a;
          b_next       = b;
          exact_next   = exact;
          creg_next    = {g_vec[S-2:0], cin};
          fix_cnt_next = '0;
          state_next   = CHECK;
        end
      end

      CHECK: begin
        if (exact_reg && (nxt_carry != creg_reg)) begin
          creg_next    = nxt_carry;
          fix_cnt_next = fix_cnt_reg + FW'(1);
        end else begin
          sum_next = slice_sum;
          if (exact_reg) begin
            cout_next = g_vec[S-1] | (p_vec[S-1] & creg_reg[S-1]);
            err_next  = (fix_cnt_reg != '0);
          end else begin
            // Approximate result: top carry ignores its carry-in, and any slice
            // whose guessed carry-in would have propagated is flagged.
            cout_next = g_vec[S-1];
            err_next  = |(p_vec & creg_reg);
          end
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == HOLD);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign err_flag  = err_reg;
  assign fix_cnt   = fix_cnt_reg;

endmodule : approx_add_recover

// File: tb/tb_approx_add_recover.sv
module tb_approx_add_recover;

  localparam int WIDTH = 16;
  localparam int S     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             exact;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err_flag;
  logic [2:0]       fix_cnt;

  int checks = 0;
  int errors = 0;

  approx_add_recover #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .exact     (exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err_flag  (err_flag),
    .fix_cnt   (fix_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: slice carries computed with plain 4-bit arithmetic.
  // Initial guess for slice k>0 is the carry of slice k-1 added with no
  // carry-in; exact mode repeats the ripple step until nothing changes.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic mcin, input logic mexact,
                                output logic [WIDTH-1:0] ms, output logic mco,
                                output logic mer, output int mfx);
    int c [S];
    int cn [S];
    int sa, sb;
    bit changed;
    c[0] = int'(mcin);
    for (int k = 1; k < S; k++)
      c[k] = (int'(ma[(k-1)*4 +: 4]) + int'(mb[(k-1)*4 +: 4])) >> 4;
    mfx = 0;
    if (mexact) begin
      for (int it = 0; it < 10; it++) begin
        cn[0] = c[0];
        for (int k = 1; k < S; k++)
          cn[k] = (int'(ma[(k-1)*4 +: 4]) + int'(mb[(k-1)*4 +: 4]) + c[k-1]) >> 4;
        changed = 0;
        for (int k = 0; k < S; k++) if (cn[k] != c[k]) changed = 1;
        if (!changed) break;
        for (int k = 0; k < S; k++) c[k] = cn[k];
        mfx++;
      end
    end
    ms  = '0;
    mer = 1'b0;
    for (int k = 0; k < S; k++) begin
      sa = int'(ma[k*4 +: 4]);
      sb = int'(mb[k*4 +: 4]);
      ms[k*4 +: 4] = 4'((sa + sb + c[k]) & 15);
      if (((sa + sb + c[k]) >> 4) != ((sa + sb) >> 4)) mer = 1'b1;
    end
    sa = int'(ma[WIDTH-1 -: 4]);
    sb = int'(mb[WIDTH-1 -: 4]);
    mco = mexact ? 1'((sa + sb + c[S-1]) >> 4) : 1'((sa + sb) >> 4);
    if (mexact) mer = (mfx != 0);
  endfunction

  // Present operands at an idle point and complete the accepting edge;
  // afterwards the inputs are scrambled to show they are no longer sampled.
  task automatic start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic tcin, input logic tex);
    int n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb_; cin = tcin; exact = tex; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    cin = 1'($urandom); exact = 1'($urandom);
  endtask

  task automatic run_txn(input string name, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb_, input logic tcin,
                         input logic tex, input int hold);
    logic [WIDTH-1:0] es;
    logic eco, eer;
    int efx, lat;
    logic [WIDTH:0] full;
    model(ta, tb_, tcin, tex, es, eco, eer, efx);
    out_ready = 1'b0;
    start(ta, tb_, tcin, tex);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_latency"}, lat, 1 + efx);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, eco);
    check({name, "_err"}, err_flag, eer);
    check({name, "_fix_cnt"}, fix_cnt, efx);
    check({name, "_in_ready_busy"}, in_ready, 0);
    if (tex) begin
      full = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tcin};
      check({name, "_exact_arith"}, {cout, sum}, full);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_sum"}, sum, es);
      check({name, "_hold_meta"}, {cout, err_flag, fix_cnt}, {eco, eer, 3'(efx)});
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_release_valid"}, out_valid, 0);
    check({name, "_release_in_ready"}, in_ready, 1);
    $display("txn %s a=%h b=%h cin=%0d exact=%0d -> sum=%h cout=%0d err=%0d fix=%0d lat=%0d",
             name, ta, tb_, tcin, tex, sum, cout, err_flag, fix_cnt, lat);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; exact = 1'b0;
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_meta", {cout, err_flag, fix_cnt}, 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_reset_in_ready", in_ready, 1);
    check("after_reset_out_valid", out_valid, 0);

    // Directed cases
    run_txn("ff_plus1_exact", 16'h00FF, 16'h0001, 1'b0, 1'b1, 0);
    run_txn("ff_plus1_approx", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
    run_txn("ffff_cin_exact", 16'hFFFF, 16'h0000, 1'b1, 1'b1, 0);
    run_txn("no_carry_exact", 16'h1234, 16'h4321, 1'b0, 1'b1, 0);
    run_txn("hold5", 16'h0FF0, 16'h0011, 1'b1, 1'b1, 5);
    run_txn("ffff_cin_approx", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);

    // Randomized cases; half bias towards long propagate chains
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 2 == 0) ? ~ra ^ WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom);
      run_txn($sformatf("rand%0d", i), ra, rb, 1'($urandom), 1'($urandom),
              $urandom_range(0, 2));
    end

    // Reset in the middle of the long exact iteration
    run_txn("pre_reset", 16'h1111, 16'h2222, 1'b0, 1'b1, 0);
    start(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("mid_check_fix_cnt", fix_cnt, 1);
    check("mid_check_out_valid", out_valid, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_sum", sum, 0);
    check("rst_async_meta", {cout, err_flag, fix_cnt}, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_held_out_valid", out_valid, 0);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_sum", sum, 0);
      check("post_rst_in_ready", in_ready, 1);
    end
    $display("txn reset_during_check -> out_valid=%0d sum=%h fix=%0d", out_valid, sum, fix_cnt);

    run_txn("after_reset", 16'hABCD, 16'h1234, 1'b1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_approx_add_recover
